mdio_controller: RTL and testbench

Station-management (host) side of the MDIO link. It sits directly upstream of the MDIO peripheral and drives its MDC, MDIO_OUT and MDIO_OE inputs. It also samples the peripheral's MDIO_IN output. Each transaction is a 32-bit Clause-22 frame loaded in parallel; the block serialises it MSB-first and, for reads, returns the 16-bit register value.

---
 rtl/mdio_pkg.sv | 24 ++
 rtl/mdc_gen.sv | 47 ++++
 rtl/mdio_controller.sv | 140 ++++++++++++++
 tb/tb_mdio_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: Clause-22 frame layout, opcodes and FSM encoding.
// Used by both the station-management controller and the peripheral.
package mdio_pkg;

    localparam int FRAME_BITS      = 32;
    localparam int DATA_BITS       = 16;
    localparam int ADDR_FIELD_END  = 13;
    localparam int RD_SAMPLE_START = 16;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST_CODE  = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } mdio_state_e;

    function automatic logic is_read_op(input logic [1:0] op);
        return op == OP_READ;
    endfunction

endpackage

// File: rtl/mdc_gen.sv
// MDC divider: low for MDC_DIV cycles then high for MDC_DIV cycles while enabled,
// with strobes that are high in the cycle whose closing CLK edge moves MDC.
module mdc_gen #(
    parameter int MDC_DIV = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic enable,
    output logic mdc,
    output logic mdc_rise_pulse,
    output logic mdc_fall_pulse
);

    localparam logic [7:0] DIV_LAST = 8'(MDC_DIV - 1);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       mdc_q, mdc_d;
    logic       phase_end;

    always_comb begin
        phase_end      = enable && (div_cnt_q == DIV_LAST);
        mdc_rise_pulse = phase_end && !mdc_q;
        mdc_fall_pulse = phase_end && mdc_q;
        div_cnt_d      = div_cnt_q + 8'd1;
        mdc_d          = mdc_q;
        if (!enable) begin
            div_cnt_d = 8'd0;
            mdc_d     = 1'b0;
        end else if (phase_end) begin
            div_cnt_d = 8'd0;
            mdc_d     = ~mdc_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt_q <= 8'd0;
            mdc_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            mdc_q     <= mdc_d;
        end
    end

    assign mdc = mdc_q;

endmodule

// File: rtl/mdio_controller.sv
// MDIO station-management controller: serialises a 32-bit Clause-22 frame
// MSB-first on MDC falls and, for reads, captures 16 data bits on MDC rises.
module mdio_controller
    import mdio_pkg::*;
#(
    parameter int MDC_DIV = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 MDIO_START,
    input  logic [31:0]          T_DATA,
    input  logic                 MDIO_IN,
    output logic                 MDC,
    output logic                 MDIO_OUT,
    output logic                 MDIO_OE,
    output logic [DATA_BITS-1:0] RD_DATA,
    output logic                 DATA_RDY,
    output logic                 MDIO_BUSY
);

    mdio_state_e          state_q, state_d;
    logic [30:0]          tx_q, tx_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic                 is_read_q, is_read_d;
    logic                 out_q, out_d;
    logic                 oe_q, oe_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                 data_rdy_q, data_rdy_d;

    logic mdc_rise, mdc_fall;

    mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc_gen (
        .CLK            (CLK),
        .RESET          (RESET),
        .enable         (state_q == SHIFT),
        .mdc            (MDC),
        .mdc_rise_pulse (mdc_rise),
        .mdc_fall_pulse (mdc_fall)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        is_read_d  = is_read_q;
        out_d      = out_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        rd_data_d  = rd_data_q;
        data_rdy_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (MDIO_START) begin
                    state_d   = SHIFT;
                    tx_d      = T_DATA[30:0];
                    rx_d      = '0;
                    bit_cnt_d = 5'd0;
                    is_read_d = is_read_op(T_DATA[29:28]);
                    out_d     = T_DATA[31];
                    oe_d      = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            SHIFT: begin
                if (mdc_rise && is_read_q && (bit_cnt_q >= 5'(RD_SAMPLE_START))) begin
                    rx_d = {rx_q[DATA_BITS-2:0], MDIO_IN};
                end
                // A fall either begins the next bit or closes bit 31's high phase.
                if (mdc_fall) begin
                    if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                        state_d   = DONE;
                        bit_cnt_d = 5'd0;
                        out_d     = 1'b0;
                        oe_d      = 1'b0;
                        busy_d    = 1'b0;
                        if (is_read_q) begin
                            rd_data_d  = rx_q;
                            data_rdy_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        tx_d      = {tx_q[29:0], 1'b0};
                        if (is_read_q && (bit_cnt_q >= 5'(ADDR_FIELD_END))) begin
                            out_d = 1'b0;
                            oe_d  = 1'b0;
                        end else begin
                            out_d = tx_q[30];
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= 5'd0;
            is_read_q  <= 1'b0;
            out_q      <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rd_data_q  <= '0;
            data_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            is_read_q  <= is_read_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            data_rdy_q <= data_rdy_d;
        end
    end

    assign MDIO_OUT  = out_q;
    assign MDIO_OE   = oe_q;
    assign MDIO_BUSY = busy_q;
    assign RD_DATA   = rd_data_q;
    assign DATA_RDY  = data_rdy_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Directed bench for mdio_controller: one MDC_DIV=1 and one MDC_DIV=3 instance
// sharing a behavioural MDIO peripheral selected through a monitor mux.
module tb_mdio_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;
    logic [31:0] tdata;
    logic        mdio_in = 1'b0;

    logic        mdc_a, out_a, oe_a, rdy_a, busy_a;
    logic [15:0] rd_a;
    logic        mdc_b, out_b, oe_b, rdy_b, busy_b;
    logic [15:0] rd_b;

    logic        mdc_m, out_m, oe_m, rdy_m, busy_m;
    logic [15:0] rd_m;

    int total = 0;
    int bad   = 0;

    logic [31:0] per_cap;
    logic [15:0] per_rdval;
    int          per_rises;

    int          busy_cnt, oe_cnt, rdy_cnt, rdy_at, oe_fall_at;
    int          run_len, run_min, run_max, run_cnt;
    logic [15:0] rd_at_rdy;
    logic        prev_mdc, prev_busy;

    always #5 clk = ~clk;

    mdio_controller #(.MDC_DIV(1)) dut_a (
        .CLK        (clk),
        .RESET      (reset),
        .MDIO_START (start && !sel),
        .T_DATA     (tdata),
        .MDIO_IN    (mdio_in),
        .MDC        (mdc_a),
        .MDIO_OUT   (out_a),
        .MDIO_OE    (oe_a),
        .RD_DATA    (rd_a),
        .DATA_RDY   (rdy_a),
        .MDIO_BUSY  (busy_a)
    );

    mdio_controller #(.MDC_DIV(3)) dut_b (
        .CLK        (clk),
        .RESET      (reset),
        .MDIO_START (start && sel),
        .T_DATA     (tdata),
        .MDIO_IN    (mdio_in),
        .MDC        (mdc_b),
        .MDIO_OUT   (out_b),
        .MDIO_OE    (oe_b),
        .RD_DATA    (rd_b),
        .DATA_RDY   (rdy_b),
        .MDIO_BUSY  (busy_b)
    );

    assign mdc_m  = sel ? mdc_b  : mdc_a;
    assign out_m  = sel ? out_b  : out_a;
    assign oe_m   = sel ? oe_b   : oe_a;
    assign rdy_m  = sel ? rdy_b  : rdy_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign rd_m   = sel ? rd_b   : rd_a;

    // Peripheral model: captures MDIO_OUT on MDC rise, drives read data after MDC fall.
    always @(posedge mdc_m) begin
        per_cap   = {per_cap[30:0], out_m};
        per_rises = per_rises + 1;
    end

    always @(negedge mdc_m) begin
        if (per_rises == 14 || per_rises == 15)
            mdio_in = 1'b1;
        else if (per_rises >= 16 && per_rises <= 31)
            mdio_in = per_rdval[31 - per_rises];
        else
            mdio_in = 1'b0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] frame, input logic [15:0] rdval);
        per_cap   = 32'h0;
        per_rises = 0;
        per_rdval = rdval;
        mdio_in   = 1'b0;
        tdata     = frame;
        start     = 1'b1;
        step(1);
        start     = 1'b0;
    endtask

    // Samples one interval per CLK; s1/s2 inject spurious starts in those intervals.
    task automatic observe(input int n, input int s1, input int s2);
        busy_cnt   = 0;
        oe_cnt     = 0;
        rdy_cnt    = 0;
        rdy_at     = -1;
        oe_fall_at = -1;
        rd_at_rdy  = 16'h0;
        run_len    = 0;
        run_min    = 1000;
        run_max    = 0;
        run_cnt    = 0;
        prev_mdc   = 1'b0;
        prev_busy  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == s1 || i == s2) begin
                start = 1'b1;
                tdata = 32'h5FFFFFFF;
            end else begin
                start = 1'b0;
            end
            if (busy_m) busy_cnt++;
            if (oe_m) oe_cnt++;
            if (busy_m && !oe_m && oe_fall_at < 0) oe_fall_at = i;
            if (rdy_m) begin
                rdy_cnt++;
                if (rdy_at < 0) begin
                    rdy_at    = i;
                    rd_at_rdy = rd_m;
                end
            end
            if (i > 0 && mdc_m != prev_mdc) begin
                if (prev_busy) begin
                    run_cnt++;
                    if (run_len < run_min) run_min = run_len;
                    if (run_len > run_max) run_max = run_len;
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_mdc  = mdc_m;
            prev_busy = busy_m;
            step(1);
        end
        start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        sel       = 1'b0;
        tdata     = 32'h0;
        per_cap   = 32'h0;
        per_rises = 0;
        per_rdval = 16'h0;

        step(3);
        check_output("rst_mdc_a",  mdc_a,  0);
        check_output("rst_oe_a",   oe_a,   0);
        check_output("rst_out_a",  out_a,  0);
        check_output("rst_busy_a", busy_a, 0);
        check_output("rst_rdy_a",  rdy_a,  0);
        check_output("rst_rd_a",   rd_a,   0);
        check_output("rst_busy_b", busy_b, 0);
        check_output("rst_mdc_b",  mdc_b,  0);
        reset = 1'b0;
        step(2);

        $display("[TB] write frame, MDC_DIV=1");
        apply_stimulus(32'h52C2ABCD, 16'h0000);
        check_output("wr_start_busy", busy_m, 1);
        check_output("wr_start_mdc",  mdc_m,  0);
        check_output("wr_start_oe",   oe_m,   1);
        check_output("wr_start_out",  out_m,  0);
        observe(70, -1, -1);
        check_output("wr_busy_cycles", busy_cnt, 64);
        check_output("wr_oe_cycles",   oe_cnt,   64);
        check_output("wr_rdy_cnt",     rdy_cnt,  0);
        check_output("wr_serial",      per_cap,  32'h52C2ABCD);
        check_output("wr_regad",       per_cap[22:18], 5'h10);
        check_output("wr_data",        per_cap[15:0],  16'hABCD);
        check_output("wr_mdc_rises",   per_rises, 32);

        $display("[TB] read frame, MDC_DIV=1");
        apply_stimulus(32'h62C00000, 16'h1234);
        observe(70, -1, -1);
        check_output("rd_oe_fall",   oe_fall_at, 28);
        check_output("rd_rdy_at",    rdy_at,     64);
        check_output("rd_rdy_cnt",   rdy_cnt,    1);
        check_output("rd_data_rdy",  rd_at_rdy,  16'h1234);
        check_output("rd_data_hold", rd_m,       16'h1234);
        check_output("rd_busy",      busy_cnt,   64);
        check_output("rd_oe_cycles", oe_cnt,     28);

        $display("[TB] start while busy");
        apply_stimulus(32'h52C2ABCD, 16'h0000);
        observe(140, 10, 64);
        check_output("bsy_busy_cycles", busy_cnt,  64);
        check_output("bsy_serial",      per_cap,   32'h52C2ABCD);
        check_output("bsy_rises",       per_rises, 32);
        check_output("bsy_rdy_cnt",     rdy_cnt,   0);
        check_output("bsy_rd_kept",     rd_m,      16'h1234);

        $display("[TB] reset mid-frame");
        apply_stimulus(32'h62C00000, 16'hBEEF);
        observe(20, -1, -1);
        reset = 1'b1;
        #1;
        check_output("mid_rst_mdc",  mdc_m,  0);
        check_output("mid_rst_oe",   oe_m,   0);
        check_output("mid_rst_busy", busy_m, 0);
        check_output("mid_rst_rd",   rd_m,   0);
        step(1);
        reset = 1'b0;
        observe(80, -1, -1);
        check_output("mid_rst_no_rdy",  rdy_cnt,  0);
        check_output("mid_rst_no_busy", busy_cnt, 0);
        apply_stimulus(32'h62C00000, 16'h5A5A);
        observe(70, -1, -1);
        check_output("post_rst_rdy_at", rdy_at,    64);
        check_output("post_rst_data",   rd_at_rdy, 16'h5A5A);
        check_output("post_rst_busy",   busy_cnt,  64);

        $display("[TB] divider, MDC_DIV=3");
        sel = 1'b1;
        step(1);
        apply_stimulus(32'h62C00000, 16'h8001);
        observe(200, -1, -1);
        check_output("div_busy_cycles", busy_cnt,   192);
        check_output("div_rdy_at",      rdy_at,     192);
        check_output("div_data",        rd_at_rdy,  16'h8001);
        check_output("div_run_min",     run_min,    3);
        check_output("div_run_max",     run_max,    3);
        check_output("div_run_cnt",     run_cnt,    64);
        check_output("div_oe_fall",     oe_fall_at, 84);
        sel = 1'b0;
        step(1);

        $display("[TB] back-to-back frames");
        apply_stimulus(32'h62C00000, 16'hC3C3);
        observe(65, -1, -1);
        check_output("b2b_rd_rdy_at", rdy_at,    64);
        check_output("b2b_rd_data",   rd_at_rdy, 16'hC3C3);
        apply_stimulus(32'h52C20F0F, 16'h0000);
        check_output("b2b_wr_accept", busy_m, 1);
        observe(65, -1, -1);
        check_output("b2b_wr_serial", per_cap, 32'h52C20F0F);
        check_output("b2b_wr_rdy",    rdy_cnt, 0);
        check_output("b2b_wr_rd_kept", rd_m,   16'hC3C3);
        apply_stimulus(32'h72C25555, 16'h0000);
        check_output("op11_accept", busy_m, 1);
        observe(70, -1, -1);
        check_output("op11_oe_cycles", oe_cnt,     64);
        check_output("op11_oe_fall",   oe_fall_at, -1);
        check_output("op11_serial",    per_cap,    32'h72C25555);
        check_output("op11_rdy",       rdy_cnt,    0);
        check_output("op11_rd_kept",   rd_m,       16'hC3C3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
